// File: rtl/score_ctrl.sv
// Scoreboard sequencing controller: parses the PS/2 scan-code stream, suppresses
// typematic repeat, and owns the saturating HOME/GUEST scores and the run flag.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_MAKE    | idle; next non-prefix byte is a make code
// ST_BRK     | F0 seen; next byte is a key release, never decoded
// ST_EXT     | E0 seen; next byte is an extended make (ignored) or F0
// ST_EXT_BRK | E0 F0 seen; next byte is an extended release (ignored)
module score_ctrl #(
    parameter int          SCORE_W   = 8,
    parameter int          SCORE_MAX = 199,
    parameter logic [7:0]  BRK_CODE  = 8'hF0,
    parameter logic [7:0]  EXT_CODE  = 8'hE0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               code_valid,
    input  logic [7:0]         code,
    input  logic               enable,
    input  logic               clr,
    output logic               running,
    output logic [SCORE_W-1:0] home_score,
    output logic [SCORE_W-1:0] guest_score,
    output logic               upd
);

    typedef enum logic [1:0] {
        ST_MAKE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } state_t;

    localparam logic [SCORE_W:0] MAX_W = (SCORE_W + 1)'(SCORE_MAX);

    state_t             state;
    logic [7:0]         last_make;
    logic               is_make;
    logic               act;
    logic [1:0]         home_inc, home_dec, guest_inc, guest_dec;
    logic               toggle;
    logic [SCORE_W-1:0] home_nxt, guest_nxt;

    // Saturating update at SCORE_W+1 bits so the add cannot wrap before the clamp.
    function automatic logic [SCORE_W-1:0] sat_step(input logic [SCORE_W-1:0] cur,
                                                    input logic [1:0] inc,
                                                    input logic [1:0] dec);
        logic [SCORE_W:0] w;
        logic [SCORE_W:0] i;
        logic [SCORE_W:0] d;
        w = {1'b0, cur};
        i = {{(SCORE_W-1){1'b0}}, inc};
        d = {{(SCORE_W-1){1'b0}}, dec};
        if (i != '0) begin
            w = w + i;
            if (w > MAX_W) w = MAX_W;
        end else if (d != '0) begin
            if (w < d) w = '0;
            else       w = w - d;
        end
        return w[SCORE_W-1:0];
    endfunction

    always_comb begin
        is_make   = code_valid && (state == ST_MAKE) && (code != BRK_CODE) &&
                    (code != EXT_CODE) && (code != last_make);
        act       = is_make && enable;
        home_inc  = 2'd0;
        home_dec  = 2'd0;
        guest_inc = 2'd0;
        guest_dec = 2'd0;
        toggle    = 1'b0;
        if (act) begin
            case (code)
                8'h1C: home_inc  = 2'd1;
                8'h1B: home_inc  = 2'd2;
                8'h23: home_inc  = 2'd3;
                8'h3B: guest_inc = 2'd1;
                8'h42: guest_inc = 2'd2;
                8'h4B: guest_inc = 2'd3;
                8'h22: home_dec  = 2'd1;
                8'h21: home_dec  = 2'd2;
                8'h2A: home_dec  = 2'd3;
                8'h32: guest_dec = 2'd1;
                8'h31: guest_dec = 2'd2;
                8'h3A: guest_dec = 2'd3;
                8'h29: toggle    = 1'b1;
                default: ;
            endcase
        end
        home_nxt  = clr ? '0 : sat_step(home_score, home_inc, home_dec);
        guest_nxt = clr ? '0 : sat_step(guest_score, guest_inc, guest_dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_MAKE;
            last_make   <= 8'h00;
            running     <= 1'b0;
            home_score  <= '0;
            guest_score <= '0;
            upd         <= 1'b0;
        end else begin
            if (code_valid) begin
                case (state)
                    ST_MAKE: begin
                        if (code == BRK_CODE)      state <= ST_BRK;
                        else if (code == EXT_CODE) state <= ST_EXT;
                        else if (is_make)          last_make <= code;
                    end
                    ST_BRK: begin
                        state <= ST_MAKE;
                        if (code == last_make) last_make <= 8'h00;
                    end
                    ST_EXT:     state <= (code == BRK_CODE) ? ST_EXT_BRK : ST_MAKE;
                    ST_EXT_BRK: state <= ST_MAKE;
                    default:    state <= ST_MAKE;
                endcase
            end
            home_score  <= home_nxt;
            guest_score <= guest_nxt;
            upd         <= (home_nxt != home_score) || (guest_nxt != guest_score);
            if (!enable)     running <= 1'b0;
            else if (toggle) running <= ~running;
        end
    end

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: directed scenarios then random byte streams, each cycle
// compared against a behavioural scoreboard model.
module tb_score_ctrl;

    logic       clk = 1'b0;
    logic       rst, code_valid, enable, clr;
    logic [7:0] code;
    logic       running, upd;
    logic [7:0] home_score, guest_score;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    int      m_home, m_guest;
    bit      m_run, m_upd;
    int      m_mode;            // 0 idle, 1 after F0, 2 after E0, 3 after E0 F0
    bit [7:0] m_last;

    score_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .code_valid (code_valid),
        .code       (code),
        .enable     (enable),
        .clr        (clr),
        .running    (running),
        .home_score (home_score),
        .guest_score(guest_score),
        .upd        (upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v < 0)   return 0;
        if (v > 199) return 199;
        return v;
    endfunction

    task automatic model(input bit r, input bit v, input bit [7:0] c, input bit en, input bit cl);
        int  dh, dg, nh, ng;
        bit  dec, tog;
        if (r) begin
            m_home = 0; m_guest = 0; m_run = 0; m_upd = 0; m_mode = 0; m_last = 8'h00;
            return;
        end
        dec = 0; dh = 0; dg = 0; tog = 0;
        if (v) begin
            if (m_mode == 1) begin
                m_mode = 0;
                if (c == m_last) m_last = 8'h00;
            end else if (m_mode == 2) begin
                m_mode = (c == 8'hF0) ? 3 : 0;
            end else if (m_mode == 3) begin
                m_mode = 0;
            end else if (c == 8'hF0) m_mode = 1;
            else if (c == 8'hE0) m_mode = 2;
            else if (c != m_last) begin
                m_last = c;
                dec = 1;
            end
        end
        if (dec && en) begin
            case (c)
                8'h1C: dh = 1;  8'h1B: dh = 2;  8'h23: dh = 3;
                8'h22: dh = -1; 8'h21: dh = -2; 8'h2A: dh = -3;
                8'h3B: dg = 1;  8'h42: dg = 2;  8'h4B: dg = 3;
                8'h32: dg = -1; 8'h31: dg = -2; 8'h3A: dg = -3;
                8'h29: tog = 1;
                default: ;
            endcase
        end
        nh = cl ? 0 : clamp(m_home + dh);
        ng = cl ? 0 : clamp(m_guest + dg);
        m_upd = (nh != m_home) || (ng != m_guest);
        m_home = nh;
        m_guest = ng;
        if (!en)      m_run = 0;
        else if (tog) m_run = !m_run;
    endtask

    task automatic step(input bit r, input bit v, input bit [7:0] c, input bit en, input bit cl);
        @(negedge clk);
        rst = r; code_valid = v; code = c; enable = en; clr = cl;
        model(r, v, c, en, cl);
        @(posedge clk);
        #1;
        check("home_score",  32'(home_score),  32'(m_home));
        check("guest_score", 32'(guest_score), 32'(m_guest));
        check("running",     32'(running),     32'(m_run));
        check("upd",         32'(upd),         32'(m_upd));
    endtask

    task automatic send(input bit [7:0] c, input bit en = 1'b1);
        step(1'b0, 1'b1, c, en, 1'b0);
        step(1'b0, 1'b0, 8'h00, en, 1'b0);
    endtask

    initial begin
        bit [7:0] pool [16] = '{8'h1C, 8'h1B, 8'h23, 8'h3B, 8'h42, 8'h4B, 8'h22, 8'h21,
                                8'h2A, 8'h32, 8'h31, 8'h3A, 8'h29, 8'hF0, 8'hE0, 8'h70};
        int upd_cnt;
        rst = 1'b1; code_valid = 1'b0; code = 8'h00; enable = 1'b1; clr = 1'b0;
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        check("reset_home", 32'(home_score), 32'd0);
        check("reset_run",  32'(running),    32'd0);

        // typematic: 1C x3, release, press again
        upd_cnt = 0;
        step(0, 1, 8'h1C, 1, 0); upd_cnt += int'(upd);
        step(0, 1, 8'h1C, 1, 0); upd_cnt += int'(upd);
        step(0, 1, 8'h1C, 1, 0); upd_cnt += int'(upd);
        check("typematic_hold", 32'(home_score), 32'd1);
        step(0, 1, 8'hF0, 1, 0); upd_cnt += int'(upd);
        step(0, 1, 8'h1C, 1, 0); upd_cnt += int'(upd);
        step(0, 1, 8'h1C, 1, 0); upd_cnt += int'(upd);
        step(0, 0, 8'h00, 1, 0); upd_cnt += int'(upd);
        check("typematic_second", 32'(home_score), 32'd2);
        check("typematic_upd_cnt", 32'(upd_cnt), 32'd2);

        // guest saturation
        for (int i = 0; i < 70; i++) begin
            send(8'h4B);
            send(8'hF0);
            send(8'h4B);
        end
        check("guest_sat", 32'(guest_score), 32'd199);

        // home down to 1, subtract 2 saturates at 0
        step(1, 0, 8'h00, 1, 0);
        send(8'h1C);
        send(8'h21);
        check("home_floor", 32'(home_score), 32'd0);
        send(8'hF0); send(8'h21); send(8'h21);
        check("home_floor_hold", 32'(home_score), 32'd0);

        // extended release does not touch last_make
        send(8'hF0); send(8'h21);
        send(8'hE0); send(8'hF0); send(8'h1C);
        check("ext_no_change", 32'(home_score), 32'd0);
        send(8'h1C);
        check("after_ext", 32'(home_score), 32'd1);

        // running toggle and enable gating
        send(8'h29);
        check("run_on", 32'(running), 32'd1);
        step(0, 0, 8'h00, 0, 0);
        check("run_forced_off", 32'(running), 32'd0);
        send(8'hF0, 0); send(8'h29, 0); send(8'h29, 0);
        check("run_disabled", 32'(running), 32'd0);
        check("home_disabled", 32'(home_score), 32'd1);

        // reset mid-sequence, then clr racing an action
        send(8'hF0);
        step(1, 0, 8'h00, 1, 0);
        send(8'h1C);
        check("rst_mid_seq", 32'(home_score), 32'd1);
        step(0, 1, 8'h1B, 1, 1);
        check("clr_wins", 32'(home_score), 32'd0);
        check("clr_upd", 32'(upd), 32'd1);

        // clr with space toggle
        step(0, 1, 8'h29, 1, 1);
        check("clr_toggle", 32'(running), 32'd1);

        // random streams
        for (int i = 0; i < 3000; i++) begin
            bit v, en, cl, r;
            v  = ($urandom_range(3) != 0);
            en = ($urandom_range(7) != 0);
            cl = ($urandom_range(31) == 0);
            r  = ($urandom_range(255) == 0);
            step(r, v, pool[$urandom_range(15)], en, cl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
